// File: rtl/noc_pkg.sv
// Shared NoC definitions: port encoding used by both the crossbar mux and the
// per-output arbiters, plus the arbiter state encoding.
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int SEL_W     = 3;

    typedef enum logic [SEL_W-1:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_W = 3'd2,
        PORT_E = 3'd3,
        PORT_L = 3'd4
    } port_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/noc_out_port_arbiter_if.sv
// Handshake bundle between the input FIFOs / output link and one output-port
// arbiter. The arbiter uses the slave view; the surrounding switch uses master.
interface noc_out_port_arbiter_if;
    import noc_pkg::*;

    logic [NUM_PORTS-1:0] req_i;
    logic [NUM_PORTS-1:0] tail_i;
    logic                 ready_i;
    logic [SEL_W-1:0]     sel_o;
    logic                 valid_o;
    logic [NUM_PORTS-1:0] grant_o;
    logic                 busy_o;

    modport master (
        output req_i, tail_i, ready_i,
        input  sel_o, valid_o, grant_o, busy_o
    );

    modport slave (
        input  req_i, tail_i, ready_i,
        output sel_o, valid_o, grant_o, busy_o
    );

endinterface

// File: rtl/noc_out_port_arbiter_rr_pick5.sv
// Combinational round-robin picker over five requesters: returns the first set
// request at or after ptr, wrapping 4 -> 0. Shared with the VC allocator.
module rr_pick5
    import noc_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [SEL_W-1:0]     ptr,
    output logic                 any,
    output logic [SEL_W-1:0]     idx
);

    logic [SEL_W-1:0] base;
    logic [3:0]       pos;

    // Out-of-range pointers are treated as 0 so idx can never leave 0..4.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        pos  = '0;
        base = (ptr > 3'd4) ? 3'd0 : ptr;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pos = {1'b0, base} + 4'(i);
            if (pos >= 4'd5) begin
                pos = pos - 4'd5;
            end
            if (!any && req[pos[2:0]]) begin
                any = 1'b1;
                idx = pos[2:0];
            end
        end
    end

endmodule

// File: rtl/noc_out_port_arbiter.sv
// Per-output-port arbiter: round-robin selection among five inputs with
// wormhole locking until the owner's tail flit transfers downstream.
module noc_out_port_arbiter
    import noc_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    noc_out_port_arbiter_if.slave       bus
);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] owner_q, owner_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             transfer;

    rr_pick5 u_pick (
        .req (bus.req_i),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // owner doubles as the registered mux select, so it only moves on IDLE -> LOCKED.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (transfer && bus.tail_i[owner_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (owner_q == PORT_L) ? PORT_N : owner_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.sel_o   = owner_q;
        bus.busy_o  = (state_q == LOCKED);
        bus.valid_o = (state_q == LOCKED) && bus.req_i[owner_q];
        transfer    = bus.valid_o && bus.ready_i;
        bus.grant_o = transfer ? (5'b00001 << owner_q) : 5'b00000;
    end

    a_grant_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(bus.grant_o));
    a_grant_ready: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.grant_o != '0) |-> bus.ready_i);
    a_sel_range: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.sel_o <= 3'd4);
    a_grant_locked: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.grant_o != '0) |-> (state_q == LOCKED));

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Directed, table-driven bench for noc_out_port_arbiter: each row gives the
// inputs for one cycle and the outputs expected during that same cycle.
module tb_noc_out_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    noc_out_port_arbiter_if bus();

    noc_out_port_arbiter dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] req;
        logic [4:0] tail;
        logic       ready;
        logic [2:0] sel;
        logic       valid;
        logic [4:0] grant;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input string name, input logic [4:0] req, input logic [4:0] tail,
                          input logic ready, input logic [2:0] sel, input logic valid,
                          input logic [4:0] grant, input logic busy);
        vec_t v;
        v.name = name; v.req = req; v.tail = tail; v.ready = ready;
        v.sel = sel; v.valid = valid; v.grant = grant; v.busy = busy;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic [4:0] req, input logic [4:0] tail, input logic ready);
        bus.req_i   = req;
        bus.tail_i  = tail;
        bus.ready_i = ready;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] sel, input logic valid,
                               input logic [4:0] grant, input logic busy);
        checks++;
        if (bus.sel_o !== sel) begin
            errors++;
            $display("[TB] FAIL %s sel_o: got %0d expected %0d", name, bus.sel_o, sel);
        end
        checks++;
        if (bus.valid_o !== valid) begin
            errors++;
            $display("[TB] FAIL %s valid_o: got %b expected %b", name, bus.valid_o, valid);
        end
        checks++;
        if (bus.grant_o !== grant) begin
            errors++;
            $display("[TB] FAIL %s grant_o: got %b expected %b", name, bus.grant_o, grant);
        end
        checks++;
        if (bus.busy_o !== busy) begin
            errors++;
            $display("[TB] FAIL %s busy_o: got %b expected %b", name, bus.busy_o, busy);
        end
    endtask

    // Drive one cycle's inputs, check the outputs of that cycle, then advance a clock.
    task automatic step(input string name, input logic [4:0] req, input logic [4:0] tail,
                        input logic ready, input logic [2:0] sel, input logic valid,
                        input logic [4:0] grant, input logic busy);
        applyStimulus(req, tail, ready);
        #2;
        checkOutput(name, sel, valid, grant, busy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Round-robin from rr_ptr=0 with all ports requesting single-flit packets.
        addVec("idle",      5'b00000, 5'b00000, 1'b1, 3'd0, 1'b0, 5'b00000, 1'b0);
        addVec("rr_arb_n",  5'b11111, 5'b11111, 1'b1, 3'd0, 1'b0, 5'b00000, 1'b0);
        addVec("rr_n",      5'b11111, 5'b11111, 1'b1, 3'd0, 1'b1, 5'b00001, 1'b1);
        addVec("rr_arb_s",  5'b11111, 5'b11111, 1'b1, 3'd0, 1'b0, 5'b00000, 1'b0);
        addVec("rr_s",      5'b11111, 5'b11111, 1'b1, 3'd1, 1'b1, 5'b00010, 1'b1);
        addVec("rr_arb_w",  5'b11111, 5'b11111, 1'b1, 3'd1, 1'b0, 5'b00000, 1'b0);
        addVec("rr_w",      5'b11111, 5'b11111, 1'b1, 3'd2, 1'b1, 5'b00100, 1'b1);
        addVec("rr_arb_e",  5'b11111, 5'b11111, 1'b1, 3'd2, 1'b0, 5'b00000, 1'b0);
        addVec("rr_e",      5'b11111, 5'b11111, 1'b1, 3'd3, 1'b1, 5'b01000, 1'b1);
        addVec("rr_arb_l",  5'b11111, 5'b11111, 1'b1, 3'd3, 1'b0, 5'b00000, 1'b0);
        addVec("rr_l",      5'b11111, 5'b11111, 1'b1, 3'd4, 1'b1, 5'b10000, 1'b1);
        addVec("rr_arb_n2", 5'b11111, 5'b11111, 1'b1, 3'd4, 1'b0, 5'b00000, 1'b0);
        addVec("rr_n2",     5'b11111, 5'b11111, 1'b1, 3'd0, 1'b1, 5'b00001, 1'b1);
        // Single W request; afterwards rr_ptr=3 so E beats N and L.
        addVec("w_arb",     5'b00100, 5'b00100, 1'b1, 3'd0, 1'b0, 5'b00000, 1'b0);
        addVec("w_xfer",    5'b00100, 5'b00100, 1'b1, 3'd2, 1'b1, 5'b00100, 1'b1);
        addVec("w_idle",    5'b00000, 5'b00000, 1'b1, 3'd2, 1'b0, 5'b00000, 1'b0);
        addVec("ptr3_arb",  5'b11001, 5'b11001, 1'b1, 3'd2, 1'b0, 5'b00000, 1'b0);
        addVec("ptr3_e",    5'b11001, 5'b11001, 1'b1, 3'd3, 1'b1, 5'b01000, 1'b1);
        addVec("l_arb",     5'b10000, 5'b10000, 1'b1, 3'd3, 1'b0, 5'b00000, 1'b0);
        addVec("l_xfer",    5'b10000, 5'b10000, 1'b1, 3'd4, 1'b1, 5'b10000, 1'b1);
        // N 4-flit packet while L keeps requesting; L's tail flag must not end N's lock.
        addVec("lock_arb",  5'b10001, 5'b10000, 1'b1, 3'd4, 1'b0, 5'b00000, 1'b0);
        addVec("lock_f1",   5'b10001, 5'b10000, 1'b1, 3'd0, 1'b1, 5'b00001, 1'b1);
        addVec("lock_f2",   5'b10001, 5'b10000, 1'b1, 3'd0, 1'b1, 5'b00001, 1'b1);
        addVec("lock_f3",   5'b10001, 5'b10000, 1'b1, 3'd0, 1'b1, 5'b00001, 1'b1);
        addVec("lock_f4",   5'b10001, 5'b10001, 1'b1, 3'd0, 1'b1, 5'b00001, 1'b1);
        addVec("lock_gap",  5'b10000, 5'b10000, 1'b1, 3'd0, 1'b0, 5'b00000, 1'b0);
        addVec("lock_l",    5'b10000, 5'b10000, 1'b1, 3'd4, 1'b1, 5'b10000, 1'b1);

        applyStimulus(5'b11111, 5'b00000, 1'b1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 3'd0, 1'b0, 5'b00000, 1'b0);
        rst = 1'b0;
        applyStimulus(5'b00000, 5'b00000, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].name, vecs[i].req, vecs[i].tail, vecs[i].ready,
                 vecs[i].sel, vecs[i].valid, vecs[i].grant, vecs[i].busy);
        end

        // Backpressure then FIFO bubble on owner E; N requesting during the bubble is ignored.
        step("bp_arb",    5'b01000, 5'b00000, 1'b1, 3'd4, 1'b0, 5'b00000, 1'b0);
        step("bp_f1",     5'b01000, 5'b00000, 1'b1, 3'd3, 1'b1, 5'b01000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step("bp_stall",  5'b01000, 5'b00000, 1'b0, 3'd3, 1'b1, 5'b00000, 1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            step("bp_bubble", 5'b00001, 5'b00001, 1'b1, 3'd3, 1'b0, 5'b00000, 1'b1);
        end
        step("bp_tail",   5'b01000, 5'b01000, 1'b1, 3'd3, 1'b1, 5'b01000, 1'b1);
        step("bp_idle",   5'b00000, 5'b00000, 1'b1, 3'd3, 1'b0, 5'b00000, 1'b0);

        // Reset while S owns the output mid-packet; rr_ptr would be 4 without the reset,
        // so a following S+L request distinguishes a cleared pointer.
        step("rst_arb",   5'b00010, 5'b00000, 1'b1, 3'd3, 1'b0, 5'b00000, 1'b0);
        step("rst_f1",    5'b00010, 5'b00000, 1'b1, 3'd1, 1'b1, 5'b00010, 1'b1);
        applyStimulus(5'b00010, 5'b00000, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("rst_after", 5'b10010, 5'b00010, 1'b1, 3'd0, 1'b0, 5'b00000, 1'b0);
        step("rst_s",     5'b10010, 5'b00010, 1'b1, 3'd1, 1'b1, 5'b00010, 1'b1);
        step("rst_idle",  5'b00000, 5'b00000, 1'b1, 3'd1, 1'b0, 5'b00000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
